// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock, valid/ready on both sides.
// Optional BOOTH_UNSIGNED_MODE_EN adds op_signed for unsigned operands (one extra iteration).
module booth_r4_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
`ifdef BOOTH_UNSIGNED_MODE_EN
  input  logic                 op_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int AW = WIDTH + 2;
`ifdef BOOTH_UNSIGNED_MODE_EN
  localparam int QW = WIDTH + 2;
`else
  localparam int QW = WIDTH;
`endif
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH / 2 + 1);
  localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_r4_multiplier: WIDTH must be even and >= 4");
  end

  logic [1:0]    r_state;
  logic [AW-1:0] r_a;
  logic [AW-1:0] r_mx;
  logic [QW-1:0] r_q;
  logic          r_qm1;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_product;

  logic [AW-1:0] w_mx2;
  logic [AW-1:0] w_addend;
  logic [AW-1:0] w_sum;
  logic [AW-1:0] w_a_next;
  logic [QW-1:0] w_q_next;
  logic [PW-1:0] w_result;
  logic [CW-1:0] w_last_cnt;

`ifdef BOOTH_UNSIGNED_MODE_EN
  localparam logic [CW-1:0] LAST_U = CW'(WIDTH / 2);
  logic r_signed;

  assign w_last_cnt = r_signed ? LAST_S : LAST_U;
  // Signed runs stop with the two sign-extension bits still at the bottom of Q.
  assign w_result   = r_signed ? PW'({w_a_next, w_q_next} >> 2) : PW'({w_a_next, w_q_next});
`else
  assign w_last_cnt = LAST_S;
  assign w_result   = PW'({w_a_next, w_q_next});
`endif

  assign w_mx2 = {r_mx[AW-2:0], 1'b0};

  always_comb begin
    w_addend = '0;
    case ({r_q[1:0], r_qm1})
      3'b001, 3'b010: w_addend = r_mx;
      3'b011:         w_addend = w_mx2;
      3'b100:         w_addend = ~w_mx2 + AW'(1);
      3'b101, 3'b110: w_addend = ~r_mx + AW'(1);
      default:        w_addend = '0;
    endcase
  end

  assign w_sum    = r_a + w_addend;
  assign w_a_next = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
  assign w_q_next = {w_sum[1:0], r_q[QW-1:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_mx      <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
      r_signed  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
            r_signed <= op_signed;
            if (op_signed) begin
              r_mx <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
              r_q  <= {{2{multiplier[WIDTH-1]}}, multiplier};
            end else begin
              r_mx <= {2'b00, multiplicand};
              r_q  <= {2'b00, multiplier};
            end
`else
            r_mx <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
            r_q  <= multiplier;
`endif
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_qm1 <= r_q[1];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == w_last_cnt) begin
            r_product <= w_result;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_CALC);
  assign out_valid = (r_state == S_DONE);
  assign product   = r_product;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier (WIDTH=8): directed table, random vs. arithmetic model,
// back-pressure and mid-operation reset sequences.
module tb_booth_r4_multiplier;
  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;
`ifdef BOOTH_UNSIGNED_MODE_EN
  logic          op_signed;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit sgn_mode = 1'b1;

  booth_r4_multiplier #(.WIDTH(W)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (mcand),
    .multiplier   (mplier),
`ifdef BOOTH_UNSIGNED_MODE_EN
    .op_signed    (op_signed),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  m;
    logic [W-1:0]  q;
    logic [PW-1:0] p;
  } vec_t;

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q, input bit sgn);
    longint a;
    longint b;
    a = sgn ? longint'($signed(m)) : longint'(m);
    b = sgn ? longint'($signed(q)) : longint'(q);
    return PW'(a * b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation, measure cycles from acceptance edge to out_valid, then consume it.
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        output logic [PW-1:0] p, output int lat);
    @(negedge clk);
    mcand    = m;
    mplier   = q;
    in_valid = 1'b1;
`ifdef BOOTH_UNSIGNED_MODE_EN
    op_signed = sgn_mode;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    p = product;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t          tbl[8];
    logic [PW-1:0] p;
    int            lat;
    int            exp_lat;
    logic [W-1:0]  rm;
    logic [W-1:0]  rq;

    tbl[0] = '{m: 8'h07, q: 8'h03, p: 16'h0015};
    tbl[1] = '{m: 8'h80, q: 8'h80, p: 16'h4000};
    tbl[2] = '{m: 8'h80, q: 8'h7F, p: 16'hC080};
    tbl[3] = '{m: 8'hFF, q: 8'h01, p: 16'hFFFF};
    tbl[4] = '{m: 8'h00, q: 8'h5A, p: 16'h0000};
    tbl[5] = '{m: 8'h7F, q: 8'h7F, p: 16'h3F01};
    tbl[6] = '{m: 8'hFE, q: 8'hFE, p: 16'h0004};
    tbl[7] = '{m: 8'h7F, q: 8'h80, p: 16'hC080};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mcand = '0; mplier = '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
    op_signed = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].m, tbl[i].q, p, lat);
      chk($sformatf("tbl%0d_product", i), p, tbl[i].p);
      chk($sformatf("tbl%0d_latency", i), lat, W / 2);
    end

    // Back-pressure with in_valid pulsed during the calculation.
    @(negedge clk);
    mcand = 8'h07; mplier = 8'h03; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_busy", busy, 1);
    @(negedge clk);
    mcand = 8'h55; mplier = 8'h66; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_valid_seen", out_valid, 1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_product", product, 16'h0015);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);

    // Reset after two iterations aborts the operation.
    @(negedge clk);
    mcand = 8'h33; mplier = 8'h44; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_product", product, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_output", out_valid, 0);
    run_op(8'h05, 8'hFA, p, lat);
    chk("post_rst_product", p, 16'hFFE2);
    chk("post_rst_latency", lat, W / 2);

`ifdef BOOTH_UNSIGNED_MODE_EN
    sgn_mode = 1'b0;
    run_op(8'hFF, 8'hFF, p, lat);
    chk("unsigned_product", p, 16'hFE01);
    chk("unsigned_latency", lat, W / 2 + 1);
    sgn_mode = 1'b1;
`endif

    for (int i = 0; i < 1000; i++) begin
      rm = W'($urandom);
      rq = W'($urandom);
`ifdef BOOTH_UNSIGNED_MODE_EN
      sgn_mode = ($urandom_range(0, 1) == 1);
`endif
      exp_lat = sgn_mode ? W / 2 : W / 2 + 1;
      run_op(rm, rq, p, lat);
      chk($sformatf("rand_%0h_%0h_s%0d", rm, rq, sgn_mode), p, ref_mul(rm, rq, sgn_mode));
      if (i % 50 == 0) chk("rand_latency", lat, exp_lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
